uart_loader: RTL
================

# uart_loader

Serial boot loader that receives a program image over UART and writes it word-by-word into instruction or data memory before the CPU starts. It sits upstream of IMem/DMem and produces the `upg_wen_o`/`upg_adr_o`/`upg_dat_o`/`upg_done_o` stream that top-level muxes route into the memories while the CPU is held in UART mode. It also replies on `tx` with one status byte per segment.

## Interface
Parameters:
- `CLK_HZ`, 10_000_000: frequency of `clk` in Hz.
- `BAUD`, 115200: serial bit rate. Bit period is `CLK_HZ/BAUD` cycles, truncated; the default gives 86.

Ports:
- `clk` in 1: single clock for the block (the UART clock domain).
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, 8N1, LSB first, idle high.
- `tx` out 1: serial output, 8N1, idle high.
- `upg_wen_o` out 1: one-cycle write strobe.
- `upg_adr_o` out 15: bit 14 selects the memory (0 = IMem, 1 = DMem); bits [13:0] are the word index.
- `upg_dat_o` out 32: write data, valid when `upg_wen_o` is high.
- `upg_done_o` out 1: image complete. Sticky until `reset`.

## Operation
- Host stream is a sequence of segments. Each segment is a tag byte, then `count` as a 16-bit big-endian value, then `count`×4 data bytes. Each word is little-endian.
- Tags:
  - 0x49 'I': IMem segment. Sets `upg_adr_o[14]`=0.
  - 0x44 'D': DMem segment. Sets `upg_adr_o[14]`=1.
  - 0x45 'E': end of image. Has no count field.
- Word index restarts at 0 for each segment and increments after every write.
- Receiver:
  - 2-FF synchronizer on `rx`.
  - A falling edge starts a byte. Start bit is re-checked at half a bit period; a high sample aborts silently.
  - Data bits are sampled at bit centres.
  - If the stop bit samples 0, the byte is discarded: no `rx_valid`, no error reply.
- States:
  - IDLE: waits for a tag. 'I'/'D' → CNT_HI. 'E' → DONE. Any other byte → ERR.
  - CNT_HI → CNT_LO: latches the upper count byte.
  - CNT_LO: if count = 0 → ACK. If count > 16384 → ERR. Otherwise → DATA with byte-lane = 0.
  - DATA:
    - Shifts each byte into lane 0..3.
    - On lane 3, asserts `upg_wen_o` for one cycle and increments the index.
    - After the last word → ACK.
  - ACK: queues reply 0x4B 'K' → IDLE.
  - ERR: queues reply 0x3F '?' → IDLE. No partial word is written.
  - DONE: queues 'K' once. Sets `upg_done_o`=1, ignores all further `rx` and never writes again.
- Transmitter: single-byte shifter. A reply queued while tx is busy is not possible by protocol. If it happens anyway, the new reply is dropped.

## Timing
- Reset values: `tx`=1, `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0. State = IDLE, word index and lane = 0, receiver and transmitter idle.
- `rx_valid` pulses for 1 cycle at the centre of the stop bit.
- `upg_wen_o` rises in the cycle after the `rx_valid` of a word's 4th byte.
  - `upg_adr_o` and `upg_dat_o` are stable in that cycle and held until the next write.
- `tx` start bit begins within 2 cycles of entering ACK, ERR or DONE. A reply lasts 10 bit periods.
- `upg_done_o` rises in the same cycle the FSM enters DONE.
- Index wrap: the 16384th word writes index 0x3FFF. No wrap is possible because count is capped at 16384.
- Reset asserted mid-byte or mid-segment: everything returns to reset values immediately.
  - Already-written words stay in memory.
  - The outputs carry no partial write.

## Structure
- Package `uart_loader_pkg` holds:
  - The FSM state enum.
  - Tag constants (0x49, 0x44, 0x45).
  - Reply constants (0x4B, 0x3F).
  - `MAX_WORDS`=16384.
- Sub-module `uart_rx_byte` contains the synchronizer, bit timer and shift register, and outputs `rx_byte[7:0]` and `rx_valid`.
- The tx shifter and the FSM live in `uart_loader`.

## Test plan
All runs use `CLK_HZ`=160 and `BAUD`=10, which gives 16 cycles per bit.
- **IMem load:** send 'I',0x00,0x02, then 78 56 34 12 and EF BE AD DE.
  - Two writes: adr 0x0000 data 0x12345678, then adr 0x0001 data 0xDEADBEEF.
  - `tx` replies 0x4B.
- **DMem load then end:** send 'D',0x00,0x01, then 01 00 00 00, then 'E'.
  - One write: adr 0x4000 data 0x00000001. Two 'K' replies.
  - `upg_done_o`=1 after the last reply starts, and stays 1 across further `rx` traffic.
- **Bad tag:** send 0x55 → reply 0x3F, no write. A following 'I',0,1 + 4 bytes still writes adr 0.
- **Oversize and zero count:**
  - count 0x4001 → reply '?', no writes.
  - count 0x0000 → reply 'K', no writes.
- **Framing error:** corrupt the stop bit of the 2nd data byte. That byte is ignored, and the word completes on the following good byte.
- **Reset mid-transfer:** pulse `reset` after 2 data bytes. All outputs return to reset values within the cycle. A fresh 'I' segment then writes from index 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_loader_pkg;

  // Loader protocol states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_ACK,
    ST_ERR,
    ST_DONE
  } state_t;

  // Byte receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  TAG_IMEM  = 8'h49;
  localparam logic [7:0]  TAG_DMEM  = 8'h44;
  localparam logic [7:0]  TAG_END   = 8'h45;
  localparam logic [7:0]  REPLY_OK  = 8'h4B;
  localparam logic [7:0]  REPLY_ERR = 8'h3F;
  localparam logic [15:0] MAX_WORDS = 16'd16384;

  // Clock cycles per serial bit, truncated.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, start-bit validation, centre sampling.
// A byte whose stop bit samples low is dropped without any indication.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int BIT_CYC = bit_cycles(CLK_HZ, BAUD);
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);

  logic            r_sync1, r_sync2, r_prev;
  rx_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic            r_valid, w_valid_nxt;

  // Two-stage synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_byte  <= w_byte_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state: bit timer runs from the detected edge, samples at bit centres.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1'b1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_nxt  = r_byte;
    w_valid_nxt = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = {CW{1'b0}};
        if (r_prev && !r_sync2) begin
          w_state_nxt = RX_START;
        end else begin
          w_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_cnt == CW'(HALF - 1)) begin
          w_cnt_nxt = {CW{1'b0}};
          w_bit_nxt = 3'd0;
          if (r_sync2) begin
            w_state_nxt = RX_IDLE;
          end else begin
            w_state_nxt = RX_DATA;
          end
        end else begin
          w_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (r_cnt == CW'(BIT_CYC - 1)) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_state_nxt = RX_DATA;
          end
        end else begin
          w_state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (r_cnt == CW'(BIT_CYC - 1)) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = RX_IDLE;
          if (r_sync2) begin
            w_valid_nxt = 1'b1;
            w_byte_nxt  = r_shift;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = RX_STOP;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign rx_byte  = r_byte;
  assign rx_valid = r_valid;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses tagged segments into IMem/DMem word writes and
// answers each segment with a one-byte status reply.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o
);

  localparam int BIT_CYC = bit_cycles(CLK_HZ, BAUD);
  localparam int CW      = $clog2(BIT_CYC + 1);

  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [13:0] r_idx, w_idx_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic        r_seg, w_seg_nxt;
  logic        r_wen, w_wen_nxt;
  logic [14:0] r_adr, w_adr_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic        r_done, w_done_nxt;
  logic        w_tx_start;
  logic [7:0]  w_tx_byte;

  logic [15:0] w_full_cnt;
  logic [31:0] w_word_shift;

  logic          r_tx, r_tx_busy;
  logic [8:0]    r_tx_sh;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bits;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_byte  (w_rx_byte),
    .rx_valid (w_rx_valid)
  );

  // Count assembled from the latched high byte and the incoming low byte;
  // words arrive little-endian so each byte enters at the top.
  assign w_full_cnt   = {r_cnt[15:8], w_rx_byte};
  assign w_word_shift = {w_rx_byte, r_word[31:8]};

  // Loader FSM and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'h0000;
      r_idx   <= 14'h0000;
      r_lane  <= 2'd0;
      r_word  <= 32'h0000_0000;
      r_seg   <= 1'b0;
      r_wen   <= 1'b0;
      r_adr   <= 15'h0000;
      r_dat   <= 32'h0000_0000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_lane  <= w_lane_nxt;
      r_word  <= w_word_nxt;
      r_seg   <= w_seg_nxt;
      r_wen   <= w_wen_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Segment parser: tag, big-endian count, then count little-endian words.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_lane_nxt  = r_lane;
    w_word_nxt  = r_word;
    w_seg_nxt   = r_seg;
    w_wen_nxt   = 1'b0;
    w_adr_nxt   = r_adr;
    w_dat_nxt   = r_dat;
    w_done_nxt  = r_done;
    w_tx_start  = 1'b0;
    w_tx_byte   = REPLY_OK;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_valid) begin
          case (w_rx_byte)
            TAG_IMEM: begin w_seg_nxt = 1'b0; w_state_nxt = ST_CNT_HI; end
            TAG_DMEM: begin w_seg_nxt = 1'b1; w_state_nxt = ST_CNT_HI; end
            TAG_END: begin
              // Reply and done flag are issued on entry so DONE stays inert.
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
              w_tx_start  = 1'b1;
              w_tx_byte   = REPLY_OK;
            end
            default: w_state_nxt = ST_ERR;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CNT_HI: begin
        if (w_rx_valid) begin
          w_cnt_nxt   = {w_rx_byte, 8'h00};
          w_state_nxt = ST_CNT_LO;
        end else begin
          w_state_nxt = ST_CNT_HI;
        end
      end
      ST_CNT_LO: begin
        if (w_rx_valid) begin
          w_cnt_nxt  = w_full_cnt;
          w_idx_nxt  = 14'h0000;
          w_lane_nxt = 2'd0;
          if (w_full_cnt == 16'h0000) begin
            w_state_nxt = ST_ACK;
          end else if (w_full_cnt > MAX_WORDS) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_CNT_LO;
        end
      end
      ST_DATA: begin
        if (w_rx_valid) begin
          w_word_nxt = w_word_shift;
          w_lane_nxt = r_lane + 2'd1;
          if (r_lane == 2'd3) begin
            w_wen_nxt = 1'b1;
            w_adr_nxt = {r_seg, r_idx};
            w_dat_nxt = w_word_shift;
            w_idx_nxt = r_idx + 14'd1;
            w_cnt_nxt = r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              w_state_nxt = ST_ACK;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_ACK: begin
        w_tx_start  = 1'b1;
        w_tx_byte   = REPLY_OK;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_tx_start  = 1'b1;
        w_tx_byte   = REPLY_ERR;
        w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reply shifter: start bit on load, then 8 data bits and stop; a request
  // arriving while busy is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_sh   <= 9'h1FF;
      r_tx_cnt  <= {CW{1'b0}};
      r_tx_bits <= 4'd0;
    end else if (w_tx_start && !r_tx_busy) begin
      r_tx      <= 1'b0;
      r_tx_busy <= 1'b1;
      r_tx_sh   <= {1'b1, w_tx_byte};
      r_tx_cnt  <= {CW{1'b0}};
      r_tx_bits <= 4'd0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == CW'(BIT_CYC - 1)) begin
        r_tx_cnt <= {CW{1'b0}};
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx      <= 1'b1;
        end else begin
          r_tx      <= r_tx_sh[0];
          r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
          r_tx_bits <= r_tx_bits + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + CW'(1'b1);
      end
    end else begin
      r_tx <= 1'b1;
    end
  end

  assign tx         = r_tx;
  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;

endmodule
